// File: rtl/rot_led_scheduler.sv
// rot_led_scheduler
//   Buffers rotary-shaft detent events as a signed pending-step count and
//   applies them to the LED display no faster than one step every STEP_DIV
//   clocks. The display is a rotating one-hot dot (mode=0) or a saturating
//   bar graph (mode=1).
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   rotation_event      one-cycle pulse per detent
//   rotation_direction  1 = CW (+1), 0 = CCW (-1), qualifies rotation_event
//   clear               synchronous clear of pending/counter/pos/level/overflow
//   mode                0 = one-hot dot, 1 = bar graph
//   led                 registered LED drive
//   busy                1 while steps are pending (state WAIT)
//   overflow            sticky, set when an event is dropped at saturation
//
// State  | meaning
// -------+------------------------------------------------------------
// S_IDLE | nothing pending, tick counter held at 0
// S_WAIT | steps pending, counter runs, one step per STEP_DIV clocks

module rot_led_scheduler #(
  parameter int NUM_LEDS = 8,
  parameter int STEP_DIV = 1000000,
  parameter int PEND_MAX = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rotation_event,
  input  logic                rotation_direction,
  input  logic                clear,
  input  logic                mode,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy,
  output logic                overflow
);

  localparam int CNT_W  = $clog2(STEP_DIV);
  localparam int POS_W  = $clog2(NUM_LEDS);
  localparam int LVL_W  = $clog2(NUM_LEDS + 1);
  localparam int PEND_W = $clog2(PEND_MAX + 1) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(NUM_LEDS);

  // One extra bit of headroom so pending +/- 2 never wraps before the range check.
  localparam logic signed [PEND_W:0] PMAX_S = (PEND_W + 1)'(PEND_MAX);
  localparam logic signed [PEND_W:0] ONE_S  = (PEND_W + 1)'(1);
  localparam logic signed [PEND_W:0] ZERO_S = '0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                    state;
  logic signed [PEND_W-1:0]  pending;
  logic        [CNT_W-1:0]   cnt;
  logic        [POS_W-1:0]   pos;
  logic        [LVL_W-1:0]   level;

  logic                      step_fire;
  logic                      step_up;
  logic signed [PEND_W:0]    pend_ext;
  logic signed [PEND_W:0]    step_delta;
  logic signed [PEND_W:0]    ev_delta;
  logic signed [PEND_W:0]    post_step;
  logic signed [PEND_W:0]    cand;
  logic                      drop;
  logic signed [PEND_W:0]    pending_next;
  logic        [NUM_LEDS-1:0] dot_pat;
  logic        [NUM_LEDS-1:0] bar_pat;

  always_comb begin
    pend_ext   = {pending[PEND_W-1], pending};
    // Step decision uses the pre-cycle pending value.
    step_fire  = (state == S_WAIT) && (cnt == CNT_MAX) && (pending != '0);
    step_up    = ~pending[PEND_W-1];
    step_delta = ZERO_S;
    if (step_fire) step_delta = step_up ? ONE_S : -ONE_S;
    ev_delta = ZERO_S;
    if (rotation_event) ev_delta = rotation_direction ? ONE_S : -ONE_S;
    // Range check on the post-step value so a step frees room for an event.
    post_step    = pend_ext - step_delta;
    cand         = post_step + ev_delta;
    drop         = rotation_event && ((cand > PMAX_S) || (cand < -PMAX_S));
    pending_next = drop ? post_step : cand;
    dot_pat      = {{(NUM_LEDS-1){1'b0}}, 1'b1} << pos;
    bar_pat      = ~({NUM_LEDS{1'b1}} << level);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pending  <= '0;
      cnt      <= '0;
      pos      <= '0;
      level    <= '0;
      led      <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // Display follows current pos/level, so it lags a step or clear by 1 clk.
      led <= mode ? bar_pat : dot_pat;
      if (clear) begin
        state    <= S_IDLE;
        pending  <= '0;
        cnt      <= '0;
        pos      <= '0;
        level    <= '0;
        busy     <= 1'b0;
        overflow <= 1'b0;
      end else begin
        pending <= pending_next[PEND_W-1:0];
        if (drop) overflow <= 1'b1;
        if (step_fire) begin
          if (step_up) begin
            pos <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
            if (level != LVL_FULL) level <= level + LVL_W'(1);
          end else begin
            pos <= (pos == '0) ? POS_LAST : pos - POS_W'(1);
            if (level != '0) level <= level - LVL_W'(1);
          end
        end
        case (state)
          S_IDLE: begin
            cnt <= '0;
            if (pending != '0) begin
              state <= S_WAIT;
              busy  <= 1'b1;
            end
          end
          S_WAIT: begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
            if (pending_next == ZERO_S) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rot_led_scheduler.sv
module tb_rot_led_scheduler;

  logic       clk;
  logic       reset;
  logic       rotation_event;
  logic       rotation_direction;
  logic       clear;
  logic       mode;
  logic [7:0] led;
  logic       busy;
  logic       overflow;

  int n_checks;
  int n_fail;

  rot_led_scheduler #(
    .NUM_LEDS(8),
    .STEP_DIV(4),
    .PEND_MAX(7)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .rotation_event    (rotation_event),
    .rotation_direction(rotation_direction),
    .clear             (clear),
    .mode              (mode),
    .led               (led),
    .busy              (busy),
    .overflow          (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (led !== 8'h00 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: led=%h busy=%b ovf=%b required led=00 busy=0 ovf=0", led, busy, overflow);
    end
    #2 reset = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (led !== 8'h01 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: led=%h busy=%b ovf=%b required led=01 busy=0 ovf=0", led, busy, overflow);
    end
  endtask

  task automatic test_single_step();
    rotation_event = 1'b1; rotation_direction = 1'b1;
    tick();
    rotation_event = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_on: busy=%b required 1", busy); end
      end
      if (c == 4) begin
        n_checks++;
        if (led !== 8'h01 || busy !== 1'b1) begin
          n_fail++; $display("FAIL single_pre_step: led=%h busy=%b required led=01 busy=1", led, busy);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (led !== 8'h01 || busy !== 1'b0) begin
          n_fail++; $display("FAIL single_step_edge: led=%h busy=%b required led=01 busy=0", led, busy);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (led !== 8'h02) begin n_fail++; $display("FAIL single_led: led=%h required 02", led); end
      end
    end
  endtask

  task automatic test_saturation();
    do_clear();
    rotation_direction = 1'b1;
    rotation_event = 1'b1;
    for (int c = 0; c <= 38; c++) begin
      if (c == 10) rotation_event = 1'b0;
      tick();
      if (c == 7) begin
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL sat_no_ovf_yet: ovf=%b required 0", overflow); end
      end
      if (c == 8) begin
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: ovf=%b required 1", overflow); end
      end
      if (c == 29) begin
        n_checks++;
        if (led !== 8'h40) begin n_fail++; $display("FAIL sat_led6: led=%h required 40", led); end
      end
      if (c == 30) begin
        n_checks++;
        if (led !== 8'h80) begin n_fail++; $display("FAIL sat_led7: led=%h required 80", led); end
      end
      if (c == 34) begin
        n_checks++;
        if (led !== 8'h01) begin n_fail++; $display("FAIL sat_wrap: led=%h required 01", led); end
      end
      if (c == 36) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL sat_busy_last: busy=%b required 1", busy); end
      end
      if (c == 37) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_busy_done: busy=%b required 0", busy); end
      end
      if (c == 38) begin
        n_checks++;
        if (led !== 8'h02 || overflow !== 1'b1) begin
          n_fail++; $display("FAIL sat_final: led=%h ovf=%b required led=02 ovf=1", led, overflow);
        end
      end
    end
  endtask

  task automatic test_bar_mode();
    mode = 1'b1;
    do_clear();
    rotation_direction = 1'b1;
    rotation_event = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      if (c == 3) rotation_event = 1'b0;
      tick();
      if (c == 12) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL bar_up_busy: busy=%b required 1", busy); end
      end
      if (c == 14) begin
        n_checks++;
        if (led !== 8'h07 || busy !== 1'b0) begin
          n_fail++; $display("FAIL bar_level3: led=%h busy=%b required led=07 busy=0", led, busy);
        end
      end
    end
    rotation_direction = 1'b0;
    rotation_event = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      if (c == 5) rotation_event = 1'b0;
      tick();
      if (c == 6) begin
        n_checks++;
        if (led !== 8'h03) begin n_fail++; $display("FAIL bar_down2: led=%h required 03", led); end
      end
      if (c == 10) begin
        n_checks++;
        if (led !== 8'h01) begin n_fail++; $display("FAIL bar_down1: led=%h required 01", led); end
      end
      if (c == 14) begin
        n_checks++;
        if (led !== 8'h00) begin n_fail++; $display("FAIL bar_down0: led=%h required 00", led); end
      end
      if (c == 20) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL bar_floor_busy: busy=%b required 1", busy); end
      end
      if (c == 21) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bar_floor_done: busy=%b required 0", busy); end
      end
      if (c == 22) begin
        n_checks++;
        if (led !== 8'h00) begin n_fail++; $display("FAIL bar_floor_led: led=%h required 00", led); end
      end
    end
    rotation_direction = 1'b1;
    for (int c = 0; c <= 38; c++) begin
      rotation_event = ((c % 4) == 0) && (c <= 32);
      tick();
      if (c == 30) begin
        n_checks++;
        if (led !== 8'h7f) begin n_fail++; $display("FAIL bar_level7: led=%h required 7f", led); end
      end
      if (c == 34) begin
        n_checks++;
        if (led !== 8'hff) begin n_fail++; $display("FAIL bar_full: led=%h required ff", led); end
      end
      if (c == 36) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL bar_excess_busy: busy=%b required 1", busy); end
      end
      if (c == 37) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bar_excess_done: busy=%b required 0", busy); end
      end
      if (c == 38) begin
        n_checks++;
        if (led !== 8'hff || overflow !== 1'b0) begin
          n_fail++; $display("FAIL bar_ceiling: led=%h ovf=%b required led=ff ovf=0", led, overflow);
        end
      end
    end
    rotation_event = 1'b0;
    // pos moved 0 +3 -5 +9 = 7 while the bar was displayed
    mode = 1'b0;
    tick();
    n_checks++;
    if (led !== 8'h80) begin n_fail++; $display("FAIL mode_switch_pos: led=%h required 80", led); end
  endtask

  task automatic test_event_on_step();
    do_clear();
    rotation_direction = 1'b1;
    rotation_event = 1'b1;
    tick();
    rotation_event = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin rotation_event = 1'b1; rotation_direction = 1'b0; end
      tick();
      rotation_event = 1'b0;
      if (c == 5) begin
        n_checks++;
        if (busy !== 1'b1 || led !== 8'h01) begin
          n_fail++; $display("FAIL cross_step_edge: busy=%b led=%h required busy=1 led=01", busy, led);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (led !== 8'h02) begin n_fail++; $display("FAIL cross_fwd: led=%h required 02", led); end
      end
      if (c == 8) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL cross_neg_pending: busy=%b required 1", busy); end
      end
      if (c == 9) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cross_done: busy=%b required 0", busy); end
      end
      if (c == 10) begin
        n_checks++;
        if (led !== 8'h01) begin n_fail++; $display("FAIL cross_back: led=%h required 01", led); end
      end
    end
  endtask

  task automatic test_clear_and_reset();
    do_clear();
    rotation_direction = 1'b1;
    rotation_event = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 9) clear = 1'b1;
      if (c == 10) begin clear = 1'b0; rotation_event = 1'b0; end
      tick();
      if (c == 8) begin
        n_checks++;
        if (overflow !== 1'b1 || busy !== 1'b1) begin
          n_fail++; $display("FAIL clr_pre: ovf=%b busy=%b required ovf=1 busy=1", overflow, busy);
        end
      end
      if (c == 9) begin
        n_checks++;
        if (overflow !== 1'b0 || busy !== 1'b0 || led !== 8'h02) begin
          n_fail++; $display("FAIL clr_edge: ovf=%b busy=%b led=%h required ovf=0 busy=0 led=02", overflow, busy, led);
        end
      end
      if (c == 10) begin
        n_checks++;
        if (led !== 8'h01) begin n_fail++; $display("FAIL clr_led: led=%h required 01", led); end
      end
    end
    rotation_event = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    n_checks++;
    if (busy !== 1'b0 || led !== 8'h01) begin
      n_fail++; $display("FAIL clr_no_residue: busy=%b led=%h required busy=0 led=01", busy, led);
    end
    rotation_event = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c == 2) rotation_event = 1'b0;
      tick();
    end
    n_checks++;
    if (led !== 8'h02 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: led=%h busy=%b required led=02 busy=1", led, busy);
    end
    tick();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (led !== 8'h00 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: led=%h busy=%b ovf=%b required 00/0/0", led, busy, overflow);
    end
    #2 reset = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    n_checks++;
    if (led !== 8'h01 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_partial: led=%h busy=%b required led=01 busy=0", led, busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    rotation_event = 1'b0;
    rotation_direction = 1'b0;
    clear = 1'b0;
    mode = 1'b0;
    test_reset();
    test_single_step();
    test_saturation();
    test_bar_mode();
    test_event_on_step();
    test_clear_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
